// File: rtl/recip_div_pkg.sv
// Shared constants, operand/reciprocal/product types and the reciprocal seed table
// for the reciprocal divider.
package recip_div_pkg;

  localparam int RD_W         = 16;
  localparam int RD_SEED_BITS = 6;
  localparam int RD_STAGES    = 4;

  typedef logic [RD_W-1:0] operand_t;
  typedef logic [RD_W:0]   recip_t;
  typedef logic [2*RD_W:0] prod_t;

  // Rounded-down 2^(2w)/vl at the left edge vl of each seed interval. Small divisors
  // normalise exactly onto an interval edge, so their seed is near-exact.
  function automatic logic [63:0] seed_entry(input int w, input int sb, input int idx);
    logic [63:0] vl;
    logic [63:0] val;
    logic [63:0] cap;
    vl  = (64'd1 << (w - 1)) + (64'(idx) << (w - 1 - sb));
    val = (64'd1 << (2 * w)) / vl;
    cap = (64'd1 << (w + 1)) - 64'd1;
    return (val > cap) ? cap : val;
  endfunction

endpackage

// File: rtl/recip_div_lzc.sv
// Combinational leading-zero counter; lz = W and zero = 1 for an all-zero input.
module recip_div_lzc
  import recip_div_pkg::*;
#(
  parameter int W = RD_W
) (
  input  logic [W-1:0]           a,
  output logic [$clog2(W+1)-1:0] lz,
  output logic                   zero
);

  localparam int LZW = $clog2(W + 1);

  always_comb begin
    lz = LZW'(W);
    for (int i = 0; i < W; i++) begin
      if (a[i]) lz = LZW'(W - 1 - i);
    end
  end

  assign zero = ~|a;

endmodule

// File: rtl/reciprocal_divider.sv
// Pipelined q = floor(u/v) by reciprocal multiply; 4 register stages, one pair per cycle, no backpressure.
// RECIP_DIV_REM_EN adds a registered remainder port r aligned with q.
module reciprocal_divider
  import recip_div_pkg::*;
#(
  parameter int W         = RD_W,
  parameter int SEED_BITS = RD_SEED_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] u,
  input  logic [W-1:0] v,
  output logic [W-1:0] q
`ifdef RECIP_DIV_REM_EN
  ,
  output logic [W-1:0] r
`endif
);

  localparam int LZW = $clog2(W + 1);
  localparam int RW  = W + 1;
  localparam int PW  = 2 * W + 1;
  localparam int NW  = RW + PW;
  localparam int DW  = 2 * W;
  localparam int SHW = $clog2(2 * W + 1);

  // vld marks a real operand so that flushed stages drain as q = 0
  typedef struct packed {
    logic           vld;
    logic           vz;
    logic [LZW-1:0] lz;
    logic [W-1:0]   u;
    logic [W-1:0]   v;
    logic [W-1:0]   vn;
  } s1_t;

  typedef struct packed {
    logic           vld;
    logic           vz;
    logic [LZW-1:0] lz;
    logic [W-1:0]   u;
    logic [W-1:0]   v;
    logic [RW-1:0]  recip;
  } s2_t;

  typedef struct packed {
    logic         vld;
    logic         vz;
    logic [W-1:0] u;
    logic [W-1:0] v;
    logic [W-1:0] q_est;
  } s3_t;

  s1_t s1;
  s2_t s2;
  s3_t s3;

  logic [RW-1:0] seed_lut [2**SEED_BITS];

  for (genvar gi = 0; gi < 2**SEED_BITS; gi++) begin : g_seed
    assign seed_lut[gi] = RW'(seed_entry(W, SEED_BITS, gi));
  end

  logic [LZW-1:0] in_lz;
  logic           in_vz;

  recip_div_lzc #(.W(W)) u_lzc (
    .a    (v),
    .lz   (in_lz),
    .zero (in_vz)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s1 <= '0;
    else      s1 <= '{vld: 1'b1, vz: in_vz, lz: in_lz, u: u, v: v, vn: v << in_lz};
  end

  logic [SEED_BITS-1:0] idx;
  logic [RW-1:0]        seed;
  logic [RW-1:0]        recip;
  logic [PW-1:0]        t;
  logic [PW-1:0]        e;
  logic [NW-1:0]        nr;

  // One Newton-Raphson step; R = s*(2 - x*s) never exceeds 1/x, so truncation keeps q_est low
  always_comb begin
    idx   = s1.vn[W-2 -: SEED_BITS];
    seed  = seed_lut[idx];
    t     = PW'(s1.vn) * PW'(seed);
    e     = -t;
    nr    = NW'(seed) * NW'(e);
    recip = RW'(nr >> DW);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s2 <= '0;
    else      s2 <= '{vld: s1.vld, vz: s1.vz, lz: s1.lz, u: s1.u, v: s1.v, recip: recip};
  end

  logic [PW-1:0]  p;
  logic [SHW-1:0] sh;
  logic [W-1:0]   q_est;

  always_comb begin
    p     = PW'(s2.u) * PW'(s2.recip);
    sh    = SHW'(DW) - SHW'(s2.lz);
    q_est = W'(p >> sh);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s3 <= '0;
    else      s3 <= '{vld: s2.vld, vz: s2.vz, u: s2.u, v: s2.v, q_est: q_est};
  end

  logic [W-1:0] rem0;
  logic [W-1:0] rem1;
  logic [W-1:0] q1;
  logic [W-1:0] q2;
  logic         c1;
  logic         c2;
  logic [W-1:0] q_nxt;

  // q_est is at most 2 below the true quotient, so two restoring steps make it exact
  always_comb begin
    rem0 = W'(DW'(s3.u) - DW'(s3.q_est) * DW'(s3.v));
    c1   = rem0 >= s3.v;
    q1   = s3.q_est + W'(c1);
    rem1 = c1 ? rem0 - s3.v : rem0;
    c2   = rem1 >= s3.v;
    q2   = q1 + W'(c2);
    q_nxt = '0;
    if (s3.vld) q_nxt = s3.vz ? '1 : q2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= '0;
    else      q <= q_nxt;
  end

`ifdef RECIP_DIV_REM_EN
  logic [W-1:0] rem2;
  logic [W-1:0] r_nxt;

  always_comb begin
    rem2  = c2 ? rem1 - s3.v : rem1;
    r_nxt = '0;
    if (s3.vld) r_nxt = s3.vz ? s3.u : rem2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r <= '0;
    else      r <= r_nxt;
  end
`endif

endmodule

// File: tb/tb_reciprocal_divider.sv
// Self-checking bench for reciprocal_divider: directed held pairs, back-to-back streams,
// reset flush and a random stream against a plain floor(u/v) model.
module tb_reciprocal_divider;
  import recip_div_pkg::*;

  logic     clk;
  logic     rst;
  operand_t u;
  operand_t v;
  operand_t q;
`ifdef RECIP_DIV_REM_EN
  operand_t r;
`endif

  reciprocal_divider dut (
    .clk (clk),
    .rst (rst),
    .u   (u),
    .v   (v),
    .q   (q)
`ifdef RECIP_DIV_REM_EN
    ,
    .r   (r)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic operand_t ref_q(input operand_t a, input operand_t b);
    if (b == '0) return '1;
    return a / b;
  endfunction

  function automatic operand_t ref_r(input operand_t a, input operand_t b);
    if (b == '0) return a;
    return a % b;
  endfunction

  typedef struct packed {
    operand_t a;
    operand_t b;
    operand_t qx;
    operand_t rx;
  } vec_t;

  localparam int NDIR = 12;
  localparam vec_t DIR [NDIR] = '{
    '{16'd101,   16'd25,    16'd4,     16'd1},
    '{16'd5000,  16'd100,   16'd50,    16'd0},
    '{16'd1,     16'd1,     16'd1,     16'd0},
    '{16'd0,     16'd5,     16'd0,     16'd0},
    '{16'd32767, 16'd127,   16'd258,   16'd1},
    '{16'd12345, 16'd13,    16'd949,   16'd8},
    '{16'd65535, 16'd255,   16'd257,   16'd0},
    '{16'd1234,  16'd0,     16'hFFFF,  16'd1234},
    '{16'd7,     16'd8,     16'd0,     16'd7},
    '{16'd500,   16'd500,   16'd1,     16'd0},
    '{16'd65535, 16'd1,     16'd65535, 16'd0},
    '{16'd0,     16'd0,     16'hFFFF,  16'd0}
  };

  operand_t prev_q;
  operand_t su[$];
  operand_t sv[$];

  task automatic run_held(input vec_t t);
    string nm;
    nm = $sformatf("%0d/%0d", t.a, t.b);
    @(negedge clk);
    u = t.a;
    v = t.b;
    repeat (RD_STAGES - 1) @(posedge clk);
    #1 check_eq({"latency ", nm}, q, prev_q);
    @(posedge clk);
    #1 check_eq({"q ", nm}, q, t.qx);
`ifdef RECIP_DIV_REM_EN
    check_eq({"r ", nm}, r, t.rx);
`endif
    repeat (2) @(posedge clk);
    #1 check_eq({"q hold ", nm}, q, t.qx);
    prev_q = t.qx;
  endtask

  // Pair k is driven at negedge k and must appear on q at negedge k + RD_STAGES
  task automatic run_stream(input string tag);
    int n;
    n = su.size();
    for (int k = 0; k < n + RD_STAGES; k++) begin
      @(negedge clk);
      if (k >= RD_STAGES) begin
        check_eq($sformatf("%s q %0d/%0d", tag, su[k-RD_STAGES], sv[k-RD_STAGES]),
                 q, ref_q(su[k-RD_STAGES], sv[k-RD_STAGES]));
`ifdef RECIP_DIV_REM_EN
        check_eq($sformatf("%s r %0d/%0d", tag, su[k-RD_STAGES], sv[k-RD_STAGES]),
                 r, ref_r(su[k-RD_STAGES], sv[k-RD_STAGES]));
`endif
      end
      if (k < n) begin
        u = su[k];
        v = sv[k];
      end
    end
  endtask

  task automatic gen_pair(output operand_t a, output operand_t b);
    int unsigned mode;
    mode = $urandom_range(0, 7);
    a = operand_t'($urandom);
    b = operand_t'($urandom);
    case (mode)
      3, 4: b = operand_t'($urandom) >> $urandom_range(0, 15);
      5:    a = operand_t'($urandom) >> $urandom_range(0, 15);
      6:    b = operand_t'($urandom_range(0, 2));
      7: begin
        b = operand_t'($urandom_range(1, 255));
        a = b * operand_t'($urandom_range(0, 255)) + (($urandom_range(0, 1) == 1) ? b - 16'd1 : 16'd0);
      end
      default: ;
    endcase
  endtask

  initial begin
    operand_t ra;
    operand_t rb;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    u = '0;
    v = '0;

    #12 check_eq("reset q", q, 0);
`ifdef RECIP_DIV_REM_EN
    check_eq("reset r", r, 0);
`endif

    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < RD_STAGES - 1; i++) begin
      @(posedge clk);
      #1 check_eq("post-reset q", q, 0);
    end
    @(posedge clk);
    #1 check_eq("first q 0/0", q, 16'hFFFF);
    prev_q = 16'hFFFF;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NDIR; i++) run_held(DIR[i]);

    su = '{16'd65535, 16'd65535, 16'd40000, 16'd7};
    sv = '{16'd1,     16'd65535, 16'd3,     16'd8};
    run_stream("b2b");

    su.delete();
    sv.delete();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      su.push_back(operand_t'(50000 + $urandom_range(0, 15000)));
      sv.push_back(operand_t'($urandom_range(1, 200)));
      u = su[k];
      v = sv[k];
    end
    #2 check_eq("pre-reset q", q, ref_q(su[5-RD_STAGES], sv[5-RD_STAGES]));
    rst = 1'b0;
    #1 check_eq("async reset q", q, 0);
`ifdef RECIP_DIV_REM_EN
    check_eq("async reset r", r, 0);
`endif
    repeat (2) @(posedge clk);
    #1 check_eq("reset hold q", q, 0);
    @(negedge clk);
    u = 16'd40000;
    v = 16'd3;
    rst = 1'b1;
    for (int i = 0; i < RD_STAGES - 1; i++) begin
      @(posedge clk);
      #1 check_eq("flush q", q, 0);
    end
    @(posedge clk);
    #1 check_eq("first after reset q", q, 16'd13333);
`ifdef RECIP_DIV_REM_EN
    check_eq("first after reset r", r, 16'd1);
`endif

    su.delete();
    sv.delete();
    for (int k = 0; k < 10000; k++) begin
      gen_pair(ra, rb);
      su.push_back(ra);
      sv.push_back(rb);
    end
    run_stream("rand");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
